// File: rtl/synth_buffer_scheduler.sv
// synth_buffer_scheduler: polls the PS write pointer in a BRAM control word,
// fetches ring samples in order, streams them as stereo pairs over valid/ready,
// counts underruns and (optionally) writes rptr/underrun count back for the PS.
// Optional feature macro: SYNTH_SCHED_STATUS_WB_EN (status write-back state).
module synth_buffer_scheduler #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  output logic [31:0] bram_addr,
  output logic        bram_en,
  output logic [3:0]  bram_we,
  output logic [31:0] bram_din,
  input  logic [31:0] bram_dout,
  output logic        smp_valid,
  input  logic        smp_ready,
  output logic [15:0] smp_left,
  output logic [15:0] smp_right,
  output logic        underrun,
  output logic [15:0] rptr
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RD_WPTR   = 3'd1;
  localparam logic [2:0] S_WAIT_WPTR = 3'd2;
  localparam logic [2:0] S_CHECK     = 3'd3;
  localparam logic [2:0] S_RD_SMP    = 3'd4;
  localparam logic [2:0] S_WAIT_SMP  = 3'd5;
  localparam logic [2:0] S_PRESENT   = 3'd6;
`ifdef SYNTH_SCHED_STATUS_WB_EN
  localparam logic [2:0] S_WR_STATUS = 3'd7;
`endif

  localparam logic [31:0] ADDR_WPTR   = BASE_ADDR;
  localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'd4;

  logic [2:0]    state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic          en_q, en_d;
  logic          valid_q, valid_d;
  logic [15:0]   left_q, left_d;
  logic [15:0]   right_q, right_d;
  logic          underrun_q, underrun_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [15:0]   cnt_q, cnt_d;
`ifdef SYNTH_SCHED_STATUS_WB_EN
  logic [3:0]    we_q, we_d;
  logic [31:0]   din_q, din_d;
`endif

  // Byte address of a word offset from the block base.
  function automatic logic [31:0] word_addr(input logic [31:0] idx);
    return BASE_ADDR + (idx << 2);
  endfunction

  // Next-state and registered-output decode; outputs reflect the state being entered.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    en_d       = 1'b0;
    valid_d    = 1'b0;
    left_d     = left_q;
    right_d    = right_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    underrun_d = enable && smp_ready && !valid_q;
    cnt_d      = (underrun_d && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
`ifdef SYNTH_SCHED_STATUS_WB_EN
    we_d       = 4'h0;
    din_d      = 32'h0;
`endif
    if (!enable) begin
      // Held sample is dropped; rptr stays so it is re-presented later.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_RD_WPTR;
          en_d    = 1'b1;
          addr_d  = ADDR_WPTR;
        end
        S_RD_WPTR: begin
          state_d = S_WAIT_WPTR;
        end
        S_WAIT_WPTR: begin
          wptr_d  = bram_dout[AW-1:0];
          state_d = S_CHECK;
        end
        S_CHECK: begin
          en_d = 1'b1;
          if (wptr_q == rptr_q) begin
            state_d = S_RD_WPTR;
            addr_d  = ADDR_WPTR;
          end else begin
            state_d = S_RD_SMP;
            addr_d  = word_addr(32'(rptr_q) + 32'd2);
          end
        end
        S_RD_SMP: begin
          state_d = S_WAIT_SMP;
        end
        S_WAIT_SMP: begin
          left_d  = bram_dout[31:16];
          right_d = bram_dout[15:0];
          valid_d = 1'b1;
          state_d = S_PRESENT;
        end
        S_PRESENT: begin
          if (smp_ready) begin
            rptr_d = rptr_q + AW'(1);
            en_d   = 1'b1;
`ifdef SYNTH_SCHED_STATUS_WB_EN
            state_d = S_WR_STATUS;
            addr_d  = ADDR_STATUS;
            we_d    = 4'hF;
            din_d   = {cnt_q, 16'(rptr_d)};
`else
            state_d = S_RD_WPTR;
            addr_d  = ADDR_WPTR;
`endif
          end else begin
            valid_d = 1'b1;
          end
        end
`ifdef SYNTH_SCHED_STATUS_WB_EN
        S_WR_STATUS: begin
          state_d = S_RD_WPTR;
          en_d    = 1'b1;
          addr_d  = ADDR_WPTR;
        end
`endif
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers; en and we share a flop stage so writes are atomic.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      addr_q     <= BASE_ADDR;
      en_q       <= 1'b0;
      valid_q    <= 1'b0;
      left_q     <= 16'h0;
      right_q    <= 16'h0;
      underrun_q <= 1'b0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      cnt_q      <= 16'h0;
`ifdef SYNTH_SCHED_STATUS_WB_EN
      we_q       <= 4'h0;
      din_q      <= 32'h0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      en_q       <= en_d;
      valid_q    <= valid_d;
      left_q     <= left_d;
      right_q    <= right_d;
      underrun_q <= underrun_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      cnt_q      <= cnt_d;
`ifdef SYNTH_SCHED_STATUS_WB_EN
      we_q       <= we_d;
      din_q      <= din_d;
`endif
    end
  end

  assign bram_addr = addr_q;
  assign bram_en   = en_q;
  assign smp_valid = valid_q;
  assign smp_left  = left_q;
  assign smp_right = right_q;
  assign underrun  = underrun_q;
  assign rptr      = 16'(rptr_q);
`ifdef SYNTH_SCHED_STATUS_WB_EN
  assign bram_we   = we_q;
  assign bram_din  = din_q;
`else
  assign bram_we   = 4'h0;
  assign bram_din  = 32'h0;
`endif

endmodule
